// File: rtl/mc14433_bcd_scan.sv
// -----------------------------------------------------------------------------
// mc14433_bcd_scan
//
// Output stage of the MC14433-style converter. It captures the finished
// 3 1/2-digit result on end-of-conversion and scans it out as a multiplexed
// BCD nibble with one-hot digit strobes, MSD first. It also produces the
// over/under-range flag and a registered end-of-conversion pulse.
//
// Parameters:
//   DWELL       clocks each digit strobe is held high (1..255)
//   BLANK       all-strobes-low clocks between digits (0..255)
//   URANGE_BCD  under-range threshold, 3-decade BCD
//
// Ports:
//   CP0      in   system clock, rising edge
//   R_clock  in   asynchronous active-low reset
//   eoc      in   one-cycle end-of-conversion pulse
//   msd      in   half digit (1 = leading "1")
//   bcd2/1/0 in   hundreds / tens / units BCD
//   pol      in   polarity, 1 = positive
//   ovf      in   counter overflow
//   Q        out  multiplexed digit data
//   DS       out  digit strobes, DS[3]=DS1 (MSD) .. DS[0]=DS4 (LSD)
//   EOC_o    out  registered end-of-conversion pulse
//   OR_N     out  over/under-range, active-low
//
// Optional feature macro: LEADING_ZERO_BLANK_EN
//   When defined, leading zeros in DS2/DS3 are shown as 4'hF (blank code).
// -----------------------------------------------------------------------------
module mc14433_bcd_scan #(
    parameter int unsigned DWELL      = 16,
    parameter int unsigned BLANK      = 2,
    parameter logic [11:0] URANGE_BCD = 12'h180
) (
    input  logic       CP0,
    input  logic       R_clock,
    input  logic       eoc,
    input  logic       msd,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic       pol,
    input  logic       ovf,
    output logic [3:0] Q,
    output logic [3:0] DS,
    output logic       EOC_o,
    output logic       OR_N
);

    localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
    localparam logic [7:0] BLANK_M1 = (BLANK == 0) ? 8'd0 : 8'(BLANK - 1);
    localparam logic       HAS_GAP  = (BLANK != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

    // Over-range (overflow or non-BCD digit) or under-range (small reading
    // without the half digit).
    function automatic logic f_range_fault(
        input logic       i_msd,
        input logic [3:0] i_b2,
        input logic [3:0] i_b1,
        input logic [3:0] i_b0,
        input logic       i_ovf
    );
        logic over;
        logic under;
        over  = i_ovf | (i_b2 > 4'd9) | (i_b1 > 4'd9) | (i_b0 > 4'd9);
        under = ~i_msd & ({i_b2, i_b1, i_b0} < URANGE_BCD);
        return over | under;
    endfunction

    // Pending (latest captured) result
    logic       r_p_msd, r_p_pol, r_p_ovf;
    logic [3:0] r_p_bcd2, r_p_bcd1, r_p_bcd0;
    // Display (frame in progress) result
    logic       r_d_msd, r_d_pol, r_d_fault;
    logic [3:0] r_d_bcd2, r_d_bcd1, r_d_bcd0;

    state_t     r_state, w_state_nx;
    logic [1:0] r_digit, w_digit_nx;
    logic [7:0] r_cnt, w_cnt_nx;
    logic       w_load;

    logic       r_eoc;
    logic       r_or_n;
    logic [3:0] r_q, w_q_nx;
    logic [3:0] r_ds, w_ds_nx;
    logic       w_p_fault;
    logic       w_lz2, w_lz3;

    assign w_p_fault = f_range_fault(r_p_msd, r_p_bcd2, r_p_bcd1, r_p_bcd0, r_p_ovf);

    // Capture the conversion result and register the EOC pulse
    always_ff @(posedge CP0 or negedge R_clock) begin
        if (!R_clock) begin
            r_eoc    <= 1'b0;
            r_p_msd  <= 1'b0;
            r_p_pol  <= 1'b0;
            r_p_ovf  <= 1'b0;
            r_p_bcd2 <= 4'd0;
            r_p_bcd1 <= 4'd0;
            r_p_bcd0 <= 4'd0;
        end else begin
            r_eoc <= eoc;
            if (eoc) begin
                r_p_msd  <= msd;
                r_p_pol  <= pol;
                r_p_ovf  <= ovf;
                r_p_bcd2 <= bcd2;
                r_p_bcd1 <= bcd1;
                r_p_bcd0 <= bcd0;
            end
        end
    end

    // Range flag follows the pending register one edge after each capture
    always_ff @(posedge CP0 or negedge R_clock) begin
        if (!R_clock) begin
            r_or_n <= 1'b1;
        end else if (r_eoc) begin
            r_or_n <= ~w_p_fault;
        end
    end

    // Scan FSM state, digit/dwell counters and display register
    always_ff @(posedge CP0 or negedge R_clock) begin
        if (!R_clock) begin
            r_state   <= ST_IDLE;
            r_digit   <= 2'd0;
            r_cnt     <= 8'd0;
            r_d_msd   <= 1'b0;
            r_d_pol   <= 1'b0;
            r_d_fault <= 1'b0;
            r_d_bcd2  <= 4'd0;
            r_d_bcd1  <= 4'd0;
            r_d_bcd0  <= 4'd0;
        end else begin
            r_state <= w_state_nx;
            r_digit <= w_digit_nx;
            r_cnt   <= w_cnt_nx;
            if (w_load) begin
                r_d_msd   <= r_p_msd;
                r_d_pol   <= r_p_pol;
                r_d_fault <= w_p_fault;
                r_d_bcd2  <= r_p_bcd2;
                r_d_bcd1  <= r_p_bcd1;
                r_d_bcd0  <= r_p_bcd0;
            end
        end
    end

    // Next-state logic; the display reload happens only when entering digit 1
    always_comb begin
        w_state_nx = r_state;
        w_digit_nx = r_digit;
        w_cnt_nx   = r_cnt;
        w_load     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // r_eoc is high the cycle after capture, so pending is valid
                if (r_eoc) begin
                    w_state_nx = ST_STROBE;
                    w_digit_nx = 2'd0;
                    w_cnt_nx   = 8'd0;
                    w_load     = 1'b1;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (r_cnt == DWELL_M1) begin
                    w_cnt_nx = 8'd0;
                    if (HAS_GAP) begin
                        w_state_nx = ST_GAP;
                    end else begin
                        w_digit_nx = r_digit + 2'd1;
                        w_load     = (r_digit == 2'd3);
                    end
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            ST_GAP: begin
                if (r_cnt == BLANK_M1) begin
                    w_cnt_nx   = 8'd0;
                    w_state_nx = ST_STROBE;
                    w_digit_nx = r_digit + 2'd1;
                    w_load     = (r_digit == 2'd3);
                end else begin
                    w_cnt_nx = r_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_digit_nx = 2'd0;
                w_cnt_nx   = 8'd0;
            end
        endcase
    end

    // Leading-zero detection for the blanking option
    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        w_lz2 = ~r_d_msd & (r_d_bcd2 == 4'd0);
        w_lz3 = w_lz2 & (r_d_bcd1 == 4'd0);
`else
        w_lz2 = 1'b0;
        w_lz3 = 1'b0;
`endif
    end

    // Strobe / nibble decode from the current scan position
    always_comb begin
        w_ds_nx = 4'b0000;
        w_q_nx  = 4'h0;
        if (r_state == ST_STROBE) begin
            case (r_digit)
                2'd0: begin
                    w_ds_nx = 4'b1000;
                    w_q_nx  = {~r_d_msd, r_d_pol, 1'b0, r_d_fault};
                end
                2'd1: begin
                    w_ds_nx = 4'b0100;
                    w_q_nx  = w_lz2 ? 4'hF : r_d_bcd2;
                end
                2'd2: begin
                    w_ds_nx = 4'b0010;
                    w_q_nx  = w_lz3 ? 4'hF : r_d_bcd1;
                end
                2'd3: begin
                    w_ds_nx = 4'b0001;
                    w_q_nx  = r_d_bcd0;
                end
                default: begin
                    w_ds_nx = 4'b0000;
                    w_q_nx  = 4'h0;
                end
            endcase
        end else begin
            w_ds_nx = 4'b0000;
            w_q_nx  = 4'h0;
        end
    end

    // Registered strobe and data outputs
    always_ff @(posedge CP0 or negedge R_clock) begin
        if (!R_clock) begin
            r_ds <= 4'b0000;
            r_q  <= 4'h0;
        end else begin
            r_ds <= w_ds_nx;
            r_q  <= w_q_nx;
        end
    end

    assign Q     = r_q;
    assign DS    = r_ds;
    assign EOC_o = r_eoc;
    assign OR_N  = r_or_n;

endmodule

// File: tb/tb_mc14433_bcd_scan.sv
// -----------------------------------------------------------------------------
// tb_mc14433_bcd_scan
//
// Directed testbench for mc14433_bcd_scan. Instance u_dut uses the default
// timing (DWELL=16, BLANK=2); instance u_nogap uses DWELL=3, BLANK=0 to cover
// abutting strobes. Expected strobe/nibble patterns are derived from the
// frame geometry and hand-computed DS1 nibbles.
// -----------------------------------------------------------------------------
module tb_mc14433_bcd_scan;

    logic       clk;
    logic       rst_n;
    logic       eoc;
    logic       msd;
    logic [3:0] bcd2, bcd1, bcd0;
    logic       pol;
    logic       ovf;
    logic [3:0] q0, ds0, q1, ds1;
    logic       eoc_o0, or_n0, eoc_o1, or_n1;

    // next values driven at the injected eoc inside scan()
    logic       nx_msd, nx_pol, nx_ovf;
    logic [3:0] nx_b2, nx_b1, nx_b0;

    int n_checks = 0;
    int n_errors = 0;

    mc14433_bcd_scan #(.DWELL(16), .BLANK(2), .URANGE_BCD(12'h180)) u_dut (
        .CP0(clk), .R_clock(rst_n), .eoc(eoc), .msd(msd),
        .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .pol(pol), .ovf(ovf),
        .Q(q0), .DS(ds0), .EOC_o(eoc_o0), .OR_N(or_n0)
    );

    mc14433_bcd_scan #(.DWELL(3), .BLANK(0), .URANGE_BCD(12'h180)) u_nogap (
        .CP0(clk), .R_clock(rst_n), .eoc(eoc), .msd(msd),
        .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0), .pol(pol), .ovf(ovf),
        .Q(q1), .DS(ds1), .EOC_o(eoc_o1), .OR_N(or_n1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // advance one clock and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nx(input logic m, input logic [3:0] b2, input logic [3:0] b1,
                          input logic [3:0] b0, input logic p, input logic o);
        nx_msd = m; nx_b2 = b2; nx_b1 = b1; nx_b0 = b0; nx_pol = p; nx_ovf = o;
    endtask

    task automatic drive_nx();
        msd = nx_msd; bcd2 = nx_b2; bcd1 = nx_b1; bcd0 = nx_b0; pol = nx_pol; ovf = nx_ovf;
    endtask

    // Check n cycles of scanning starting at a DS1 rising cycle (k=0).
    // Frames before sw_frame show oldq, later ones newq ({DS1,DS2,DS3,DS4}).
    // If eoc_k >= 0 an eoc carrying the nx_* value is injected after sample k.
    task automatic scan(input string tag, input int sel, input int n, input int dw,
                        input int bl, input logic [15:0] oldq, input logic [15:0] newq,
                        input int sw_frame, input int eoc_k, input logic or_old,
                        input logic or_new);
        int per, f, off, slot, pos;
        logic [15:0] nib;
        logic [3:0] eds, eq;
        logic [7:0] got;
        logic eeoc, eor;
        per = 4 * (dw + bl);
        for (int k = 0; k < n; k++) begin
            f    = k / per;
            off  = k % per;
            slot = off / (dw + bl);
            pos  = off % (dw + bl);
            nib  = (f < sw_frame) ? oldq : newq;
            if (pos < dw) begin
                eds = 4'b1000 >> slot;
                eq  = nib[15 - 4 * slot -: 4];
            end else begin
                eds = 4'b0000;
                eq  = 4'h0;
            end
            got = (sel != 0) ? {ds1, q1} : {ds0, q0};
            check({tag, ":ds_q"}, {8'h00, got}, {8'h00, eds, eq});
            if (sel == 0) begin
                eeoc = (eoc_k >= 0) && (k == eoc_k + 1);
                eor  = ((eoc_k >= 0) && (k >= eoc_k + 2)) ? or_new : or_old;
                check({tag, ":eoc_or"}, {14'h0, eoc_o0, or_n0}, {14'h0, eeoc, eor});
            end
            if (k == eoc_k) begin
                drive_nx();
                eoc = 1'b1;
            end else begin
                eoc = 1'b0;
            end
            tick();
        end
    endtask

    logic [15:0] exp_mid;

    initial begin
        rst_n = 1'b0; eoc = 1'b0; msd = 1'b0; pol = 1'b0; ovf = 1'b0;
        bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
        set_nx(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        repeat (2) tick();
        check("reset_outs", {6'h0, q0, ds0, eoc_o0, or_n0}, {6'h0, 4'h0, 4'h0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1.999 positive: EOC pulse, DS1 two edges after eoc sampled, 72-cycle frame
        msd = 1'b1; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9; pol = 1'b1; ovf = 1'b0;
        eoc = 1'b1;
        tick();
        check("eoc_pulse", {14'h0, eoc_o0, ds0 != 4'b0000}, {14'h0, 1'b1, 1'b0});
        eoc = 1'b0;
        tick();
        check("eoc_end", {12'h0, eoc_o0, or_n0, ds0 != 4'b0000, 1'b0}, {12'h0, 1'b0, 1'b1, 1'b0, 1'b0});
        tick();
        scan("f999", 0, 144, 16, 2, 16'h4999, 16'h4999, 99, -1, 1'b1, 1'b1);

        // eoc mid-DS3 with 005: current frame keeps old digits, next frame new
`ifdef LEADING_ZERO_BLANK_EN
        exp_mid = 16'hDFF5;
`else
        exp_mid = 16'hD005;
`endif
        set_nx(1'b0, 4'd0, 4'd0, 4'd5, 1'b1, 1'b0);
        scan("mid", 0, 144, 16, 2, 16'h4999, exp_mid, 1, 40, 1'b1, 1'b0);

        // overflow, msd=1, 000, negative: DS1 = 0001
        set_nx(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        scan("ovf", 0, 144, 16, 2, exp_mid, 16'h1000, 1, 10, 1'b0, 1'b0);

        // in-range 1.555 negative: OR_N returns high, DS1 = 0000
        set_nx(1'b1, 4'd5, 4'd5, 4'd5, 1'b0, 1'b0);
        scan("inrange", 0, 144, 16, 2, 16'h1000, 16'h0555, 1, 5, 1'b0, 1'b1);

        // non-BCD tens digit: over-range, A passed unmodified
        set_nx(1'b1, 4'd2, 4'hA, 4'd3, 1'b1, 1'b0);
        scan("nonbcd", 0, 144, 16, 2, 16'h0555, 16'h52A3, 1, 60, 1'b1, 1'b0);

        // async reset in the middle of DS2
        scan("pre_rst", 0, 20, 16, 2, 16'h52A3, 16'h52A3, 99, -1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {6'h0, q0, ds0, eoc_o0, or_n0}, {6'h0, 4'h0, 4'h0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("idle_after_rst", {8'h0, ds0, ds1}, 16'h0000);
        end

        // back-to-back eoc: EOC_o high for each, last value wins
        msd = 1'b1; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9; pol = 1'b1; ovf = 1'b0;
        eoc = 1'b1;
        tick();
        check("b2b_eoc1", {15'h0, eoc_o0}, 16'h0001);
        msd = 1'b0; bcd2 = 4'd1; bcd1 = 4'd7; bcd0 = 4'd9; pol = 1'b1;
        tick();
        check("b2b_eoc2", {15'h0, eoc_o0}, 16'h0001);
        eoc = 1'b0;
        tick();
        check("b2b_eoc_end", {14'h0, eoc_o0, or_n0}, 16'h0000);
        repeat (72) tick();
        scan("under179", 0, 72, 16, 2, 16'hD179, 16'hD179, 99, -1, 1'b0, 1'b0);

        // BLANK=0 instance: abutting strobes, 12-cycle frame
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        msd = 1'b1; bcd2 = 4'd9; bcd1 = 4'd9; bcd0 = 4'd9; pol = 1'b1; ovf = 1'b0;
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        check("nogap_pre", {12'h0, ds1}, 16'h0000);
        tick();
        scan("nogap", 1, 24, 3, 0, 16'h4999, 16'h4999, 99, -1, 1'b1, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
